snn_seq_ctrl: RTL and testbench
===============================

Name: snn_seq_ctrl

Overview:
Top-level sequencer for the SNN digit classifier. It owns the 1024x1 input-image RAM port and takes UART RX bytes, unpacking each LSB-first into 8 single-bit RAM writes. After NUM_BYTES bytes it starts snn_core and hands the RAM address port to the core. When the core finishes, it latches the digit and transmits it through uart_tx. It sits between uart_rx/uart_tx, ram_input_unit and snn_core, and replaces the ad hoc FSM and counters in the SNN top.

Parameters:
NUM_BYTES, 98, bytes per image (784 pixels)
ADDR_W, 10, RAM address width

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous active-high reset
rx_rdy  in  1  1-cycle pulse, rx_data valid
rx_data  in  8  received byte
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address (loader or core)
ram_wdata  out  1  pixel bit to write
core_addr  in  ADDR_W  snn_core read address
core_start  out  1  1-cycle start pulse to snn_core
core_done  in  1  1-cycle pulse, core_digit valid
core_digit  in  4  classified digit
tx_start  out  1  1-cycle start pulse to uart_tx
tx_data  out  8  {4'h0, result}
tx_rdy  in  1  uart_tx idle
led  out  8  {4'h0, last result}
busy  out  1  high in any state except IDLE
err_ovr  out  1  sticky overrun flag; cleared only by rst

Behaviour:
- All outputs are registered. Reset value of every output is 0. state=IDLE, counters=0, hold buffer empty.
- rst is sampled on posedge clk. Asserting it in any state aborts the current operation in the same edge, including partial loads and pending tx. led returns to 0.
- States: IDLE, SHIFT, START, RUN, SEND, TX_WAIT.
- IDLE: on rx_rdy, capture rx_data into the shift register (sr), clear bit_cnt, and go to SHIFT. If the hold buffer is full, consume it instead; the rx_rdy byte then goes into the hold buffer.
- SHIFT (8 cycles): ram_we=1, ram_wdata=sr[0], ram_addr=wr_addr. Each cycle: sr>>=1, wr_addr++, bit_cnt++.
  - After the 8th write:
    - if byte_cnt==NUM_BYTES-1, go to START;
    - else if the hold buffer is full, load sr from it and stay in SHIFT with byte_cnt++;
    - else byte_cnt++ and go to IDLE.
  - Addresses written are exactly 0..8*NUM_BYTES-1 (0..783). Address 784 is never written.
- rx_rdy during SHIFT: if the hold buffer is empty, store the byte there. If it is full, drop the byte and set err_ovr.
- START: core_start=1 for exactly 1 cycle, then go to RUN. wr_addr, byte_cnt and bit_cnt clear.
- RUN: ram_we=0 and ram_addr=core_addr, combinational pass-through from the port. On core_done, latch core_digit into result and led, then go to SEND.
- rx_rdy during START/RUN/SEND/TX_WAIT: byte dropped, err_ovr set.
- SEND: wait for tx_rdy=1, then tx_start=1 for 1 cycle with tx_data={4'h0,result}, and go to TX_WAIT.
- TX_WAIT: first wait for tx_rdy=0, then wait for tx_rdy=1, then go to IDLE. This tolerates a uart_tx that drops tx_rdy one cycle late.
- ram_addr mux: the core address is selected only in RUN; otherwise it is wr_addr. ram_we is never asserted outside SHIFT.
- core_done outside RUN is ignored.
- tx_data and led hold their value until the next core_done.
- Latency:
  - rx_rdy in IDLE to the first ram_we: 1 cycle.
  - Last byte's rx_rdy to core_start: 10 cycles (1 capture, 8 writes, 1 START).
  - core_done to tx_start: 1 cycle if tx_rdy=1.

Decomposition:
- Package snn_pkg holds:
  - state_t enum (logic [2:0]);
  - localparams PIX_PER_BYTE=8 and IMG_PIXELS=NUM_BYTES*8.
- One sub-module, snn_byte_unpacker, contains sr, bit_cnt, wr_addr, the hold buffer and the ram_we/ram_wdata drive. Interface: load/ack/done.

Test Plan:
- Send 98 bytes 0xA5 at UART spacing -> 784 writes, addr 0..783, bit pattern 1,0,1,0,0,1,0,1 repeating; one core_start 10 cycles after the last rx_rdy; no write to 784.
- Model core returns digit 7 via core_done -> led=8'h07, tx_start 1 cycle later with tx_data=8'h07; busy drops after tx_rdy goes 0 then 1.
- During RUN, drive core_addr=0..783 -> ram_addr follows same cycle, ram_we=0 throughout; pulse rx_rdy -> err_ovr=1, no write.
- Back-to-back bytes: rx_rdy 2 cycles apart then 3 cycles apart -> second byte held and written at addr 8..15 immediately after the first byte; third arrives with hold full -> dropped, err_ovr=1.
- Assert rst mid-SHIFT at byte 40 -> all outputs 0 next cycle; fresh 98-byte image writes from addr 0 and classifies normally.
- tx_rdy held 0 for 100 cycles after core_done -> tx_start withheld until tx_rdy=1, then exactly one pulse.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and sizing for the SNN classifier sequencer.
package snn_pkg;

   localparam int NUM_BYTES_DFLT = 98;
   localparam int PIX_PER_BYTE   = 8;
   localparam int IMG_PIXELS     = NUM_BYTES_DFLT * PIX_PER_BYTE;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SHIFT   = 3'd1;
   localparam logic [2:0] ST_START   = 3'd2;
   localparam logic [2:0] ST_RUN     = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_TX_WAIT = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      SHIFT   = ST_SHIFT,
      START   = ST_START,
      RUN     = ST_RUN,
      SEND    = ST_SEND,
      TX_WAIT = ST_TX_WAIT
   } state_t;

endpackage

// File: rtl/snn_seq_ctrl_if.sv
// Bus bundle between the sequencer and the UART / RAM / core around it.
interface snn_seq_ctrl_if #(parameter int ADDR_W = 10);
   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wdata;
   logic [ADDR_W-1:0] core_addr;
   logic              core_start;
   logic              core_done;
   logic [3:0]        core_digit;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_rdy;
   logic [7:0]        led;
   logic              busy;
   logic              err_ovr;

   modport master (
      input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
      output ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data,
             led, busy, err_ovr
   );

   modport slave (
      output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
      input  ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data,
             led, busy, err_ovr
   );
endinterface

// File: rtl/snn_byte_unpacker.sv
// Serialises received bytes LSB-first into single-bit RAM writes, with a
// one-byte hold buffer to absorb a byte that arrives mid-shift.
module snn_byte_unpacker
   import snn_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   input  logic              accept_en,
   input  logic              load,
   input  logic              clr,
   output logic              ack,
   output logic              done,
   output logic              hold_full,
   output logic              ram_we,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              ram_wdata
);

   logic [7:0]        sr_q, sr_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              we_q, we_d;
   logic [7:0]        hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              to_hold;

   always_comb begin
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      wr_addr_d   = wr_addr_q;
      we_d        = we_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      done        = we_q && (bit_cnt_q == 3'(PIX_PER_BYTE - 1));
      // A full hold only frees up when it is being loaded into sr this cycle.
      to_hold     = accept_en && rx_rdy && (hold_full_q ? load : !load);
      ack         = accept_en && rx_rdy && (!hold_full_q || load);
      if (we_q) begin
         sr_d      = sr_q >> 1;
         wr_addr_d = wr_addr_q + 1'b1;
         bit_cnt_d = bit_cnt_q + 1'b1;
         if (done) we_d = 1'b0;
      end
      if (load) begin
         sr_d        = hold_full_q ? hold_q : rx_data;
         bit_cnt_d   = '0;
         we_d        = 1'b1;
         hold_full_d = 1'b0;
      end
      if (to_hold) begin
         hold_d      = rx_data;
         hold_full_d = 1'b1;
      end
      if (clr) begin
         wr_addr_d = '0;
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         wr_addr_q   <= '0;
         we_q        <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         wr_addr_q   <= wr_addr_d;
         we_q        <= we_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   assign hold_full = hold_full_q;
   assign ram_we    = we_q;
   assign wr_addr   = wr_addr_q;
   assign ram_wdata = sr_q[0];

endmodule

// File: rtl/snn_seq_ctrl.sv
// Top sequencer: load image bytes into pixel RAM, run the core, send the digit.
module snn_seq_ctrl
   import snn_pkg::*;
#(
   parameter int NUM_BYTES = NUM_BYTES_DFLT,
   parameter int ADDR_W    = 10
) (
   input  logic           clk,
   input  logic           rst,
   snn_seq_ctrl_if.master bus
);

   localparam int BC_W = $clog2(NUM_BYTES);

   state_t            state_q, state_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic              core_start_q, core_start_d;
   logic              tx_start_q, tx_start_d;
   logic [3:0]        result_q, result_d;
   logic              seen_low_q, seen_low_d;
   logic              err_q, err_d;
   logic              busy_q;
   logic              load, clr, accept_en, ack, done, hold_full, last_byte;
   logic [ADDR_W-1:0] wr_addr;

   snn_byte_unpacker #(.ADDR_W(ADDR_W)) u_unpack (
      .clk       (clk),
      .rst       (rst),
      .rx_rdy    (bus.rx_rdy),
      .rx_data   (bus.rx_data),
      .accept_en (accept_en),
      .load      (load),
      .clr       (clr),
      .ack       (ack),
      .done      (done),
      .hold_full (hold_full),
      .ram_we    (bus.ram_we),
      .wr_addr   (wr_addr),
      .ram_wdata (bus.ram_wdata)
   );

   assign last_byte = (byte_cnt_q == BC_W'(NUM_BYTES - 1));
   assign accept_en = (state_q == IDLE) || (state_q == SHIFT);

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      core_start_d = 1'b0;
      tx_start_d   = 1'b0;
      result_d     = result_q;
      seen_low_d   = seen_low_q;
      err_d        = err_q;
      load         = 1'b0;
      clr          = 1'b0;
      if (bus.rx_rdy && !ack) err_d = 1'b1;
      case (state_q)
         IDLE: if (bus.rx_rdy || hold_full) begin
            load    = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: if (done) begin
            if (last_byte) state_d = START;
            else begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               if (hold_full) load = 1'b1;
               else state_d = IDLE;
            end
         end
         // core_start is registered off START, so it lands in the first RUN cycle.
         START: begin
            core_start_d = 1'b1;
            clr          = 1'b1;
            byte_cnt_d   = '0;
            state_d      = RUN;
         end
         RUN: if (bus.core_done) begin
            result_d   = bus.core_digit;
            tx_start_d = bus.tx_rdy;
            state_d    = SEND;
         end
         SEND: begin
            if (tx_start_q) begin
               seen_low_d = 1'b0;
               state_d    = TX_WAIT;
            end else if (bus.tx_rdy) tx_start_d = 1'b1;
         end
         // uart_tx may drop tx_rdy a cycle late; insist on seeing it low first.
         TX_WAIT: begin
            if (!seen_low_q) begin
               if (!bus.tx_rdy) seen_low_d = 1'b1;
            end else if (bus.tx_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         byte_cnt_q   <= '0;
         core_start_q <= 1'b0;
         tx_start_q   <= 1'b0;
         result_q     <= '0;
         seen_low_q   <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         core_start_q <= core_start_d;
         tx_start_q   <= tx_start_d;
         result_q     <= result_d;
         seen_low_q   <= seen_low_d;
         err_q        <= err_d;
         busy_q       <= (state_d != IDLE);
      end
   end

   assign bus.ram_addr   = (state_q == RUN) ? bus.core_addr : wr_addr;
   assign bus.core_start = core_start_q;
   assign bus.tx_start   = tx_start_q;
   assign bus.tx_data    = {4'h0, result_q};
   assign bus.led        = {4'h0, result_q};
   assign bus.busy       = busy_q;
   assign bus.err_ovr    = err_q;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Directed bench for snn_seq_ctrl: image loads, RUN pass-through, tx handshake.
module tb_snn_seq_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   snn_seq_ctrl_if #(.ADDR_W(10)) bus ();

   snn_seq_ctrl #(.NUM_BYTES(98), .ADDR_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic img_bits [1024];
   int   wr_cnt, addr_err, data_err, oob, exp_addr, cs_cnt, cs_cyc, tx_cnt;

   always @(negedge clk) begin
      if (rst) begin
         wr_cnt <= 0; addr_err <= 0; data_err <= 0; oob <= 0;
         exp_addr <= 0; cs_cnt <= 0; tx_cnt <= 0;
      end else begin
         if (bus.ram_we) begin
            wr_cnt   <= wr_cnt + 1;
            exp_addr <= exp_addr + 1;
            if (bus.ram_addr !== 10'(exp_addr)) addr_err <= addr_err + 1;
            if (bus.ram_wdata !== img_bits[bus.ram_addr]) data_err <= data_err + 1;
            if (bus.ram_addr >= 10'd784) oob <= oob + 1;
         end
         if (bus.core_start) begin
            cs_cnt   <= cs_cnt + 1;
            cs_cyc   <= cyc;
            exp_addr <= 0;
         end
         if (bus.tx_start) tx_cnt <= tx_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_rdy  = 1'b1;
      tick();
      bus.rx_rdy  = 1'b0;
   endtask

   task automatic set_byte(input int idx, input logic [7:0] b);
      for (int a = 0; a < 8; a++) img_bits[idx*8 + a] = b[a];
   endtask

   function automatic logic [7:0] pat_byte(input int pat, input int i);
      return (pat == 0) ? 8'hA5 : 8'(i * 37 + 1);
   endfunction

   task automatic send_image(input int pat, input string tag);
      int k_last;
      k_last = 0;
      for (int i = 0; i < 98; i++) set_byte(i, pat_byte(pat, i));
      for (int i = 0; i < 98; i++) begin
         k_last = cyc;
         pulse_rx(pat_byte(pat, i));
         if (i == 0) begin
            chk({tag, "_first_we"}, bus.ram_we, 1);
            chk({tag, "_first_addr"}, bus.ram_addr, 0);
            chk({tag, "_first_bit"}, bus.ram_wdata, pat_byte(pat, 0) & 8'h01);
         end
         repeat (11) tick();
      end
      chk({tag, "_start_cnt"}, cs_cnt, 1);
      chk({tag, "_start_lat"}, cs_cyc - k_last, 10);
      chk({tag, "_wr_cnt"}, wr_cnt, 784);
      chk({tag, "_addr_err"}, addr_err, 0);
      chk({tag, "_data_err"}, data_err, 0);
      chk({tag, "_oob"}, oob, 0);
   endtask

   initial begin
      int sweep_err, t0;
      rst = 1'b1;
      bus.rx_rdy = 0; bus.rx_data = 0; bus.core_addr = 0;
      bus.core_done = 0; bus.core_digit = 0; bus.tx_rdy = 1;
      for (int a = 0; a < 1024; a++) img_bits[a] = 1'b0;
      repeat (3) tick();
      chk("rst_we", bus.ram_we, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_wdata", bus.ram_wdata, 0);
      chk("rst_cstart", bus.core_start, 0);
      chk("rst_tstart", bus.tx_start, 0);
      chk("rst_tdata", bus.tx_data, 0);
      chk("rst_led", bus.led, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err_ovr, 0);
      rst = 1'b0;

      send_image(0, "img1");

      sweep_err = 0;
      for (int a = 0; a < 784; a++) begin
         bus.core_addr = 10'(a);
         #1;
         if (bus.ram_addr !== 10'(a) || bus.ram_we !== 1'b0) sweep_err++;
         tick();
      end
      chk("run_sweep", sweep_err, 0);
      chk("run_err_pre", bus.err_ovr, 0);
      pulse_rx(8'h55);
      chk("run_err_set", bus.err_ovr, 1);
      chk("run_no_we", bus.ram_we, 0);
      tick();
      chk("run_wr_cnt", wr_cnt, 784);

      t0 = tx_cnt;
      bus.core_digit = 4'd7; bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
      chk("tx_start_lat", bus.tx_start, 1);
      chk("tx_data7", bus.tx_data, 8'h07);
      chk("led7", bus.led, 8'h07);
      tick();
      chk("tx_start_1cyc", bus.tx_start, 0);
      tick();
      chk("txw_late_drop", bus.busy, 1);
      bus.tx_rdy = 0;
      repeat (4) tick();
      chk("txw_low_busy", bus.busy, 1);
      bus.tx_rdy = 1;
      tick();
      chk("txw_done_idle", bus.busy, 0);
      chk("tx_pulses1", tx_cnt - t0, 1);

      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst2_err", bus.err_ovr, 0);
      chk("rst2_led", bus.led, 0);

      set_byte(0, 8'h3C); set_byte(1, 8'hC3);
      pulse_rx(8'h3C);
      tick();
      pulse_rx(8'hC3);
      tick(); tick();
      chk("b2b_err_pre", bus.err_ovr, 0);
      pulse_rx(8'hFF);
      chk("b2b_err_drop", bus.err_ovr, 1);
      repeat (3) tick();
      chk("b2b_hold_we", bus.ram_we, 1);
      chk("b2b_hold_addr", bus.ram_addr, 8);
      chk("b2b_hold_bit", bus.ram_wdata, 1);
      repeat (8) tick();
      chk("b2b_we_off", bus.ram_we, 0);
      chk("b2b_idle", bus.busy, 0);
      chk("b2b_wr_cnt", wr_cnt, 16);
      chk("b2b_addr_err", addr_err, 0);
      chk("b2b_data_err", data_err, 0);

      for (int i = 2; i <= 40; i++) set_byte(i, 8'h5A);
      for (int i = 2; i < 40; i++) begin
         pulse_rx(8'h5A);
         repeat (11) tick();
      end
      pulse_rx(8'h5A);
      repeat (3) tick();
      chk("mid_we", bus.ram_we, 1);
      chk("mid_addr", bus.ram_addr, 323);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_we", bus.ram_we, 0);
      chk("mid_rst_addr", bus.ram_addr, 0);
      chk("mid_rst_wdata", bus.ram_wdata, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_err", bus.err_ovr, 0);
      chk("mid_rst_led", bus.led, 0);
      chk("mid_rst_tdata", bus.tx_data, 0);

      send_image(1, "img2");
      chk("img2_no_ovr", bus.err_ovr, 0);

      bus.tx_rdy = 0;
      t0 = tx_cnt;
      bus.core_digit = 4'd3; bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
      chk("led3", bus.led, 8'h03);
      repeat (100) tick();
      chk("tx_withheld", tx_cnt - t0, 0);
      chk("send_busy", bus.busy, 1);
      bus.tx_rdy = 1;
      tick();
      chk("tx_late_start", bus.tx_start, 1);
      chk("tx_data3", bus.tx_data, 8'h03);
      repeat (5) tick();
      chk("tx_one_pulse", tx_cnt - t0, 1);
      bus.tx_rdy = 0; tick();
      bus.tx_rdy = 1; tick(); tick();
      chk("tx2_idle", bus.busy, 0);

      bus.core_digit = 4'd9; bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
      tick();
      chk("done_ignored_led", bus.led, 8'h03);
      chk("done_ignored_busy", bus.busy, 0);
      chk("done_ignored_tx", tx_cnt - t0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
